// File: rtl/bc_update_sched_pkg.sv
// Shared definitions for the branch cache update scheduler: data width,
// branch-type encodings, the scheduler FSM state type and the queued update record.
package bc_update_sched_pkg;

    localparam int XLEN      = 32;
    localparam int BR_TYPE_W = 3;

    // Branch-type encodings carried in the branch cache type field.
    typedef enum logic [BR_TYPE_W-1:0] {
        BR_NONE     = 3'd0,
        BR_COND     = 3'd1,
        BR_JUMP     = 3'd2,
        BR_CALL     = 3'd3,
        BR_RET      = 3'd4,
        BR_IND      = 3'd5,
        BR_IND_CALL = 3'd6,
        BR_RSVD     = 3'd7
    } br_type_e;

    // Scheduler state: draining updates, or walking every entry to invalidate it.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } sched_state_e;

    // One pending branch cache write.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        br_type_e        br_type;
        logic [XLEN-1:0] target;
    } bc_upd_t;

    localparam int BC_UPD_W = $bits(bc_upd_t);

endpackage

// File: rtl/bc_update_sched_fifo.sv
// bc_upd_fifo: small in-order queue of pending branch cache updates.
// The caller only pushes when there is room (or a pop happens in the same cycle);
// clear empties the queue and takes priority over push and pop.
module bc_upd_fifo #(
    parameter int WIDTH      = 67,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps count steady.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
        end
    end

    // Payload storage; a full-queue push overwrites the slot being read this cycle only after the edge.
    // NOTE: storage is not reset; occupancy is tracked by the pointers, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/bc_update_sched.sv
// bc_update_sched: schedules branch cache writes from mispredict reports and
// walks the whole cache to invalidate it on flush (and after reset).
// Optional feature: define BC_UPD_BYPASS_EN to let an update that meets an idle,
// empty scheduler go straight to the write port in the same cycle.
module bc_update_sched
    import bc_update_sched_pkg::*;
#(
    parameter int BC_SIZE       = 8,
    parameter int UQ_DEPTH_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bpu_flush,
    input  logic                 wrb_update_bpu,
    input  logic [XLEN-1:0]      wrb_pc,
    input  logic                 wrb_mispred_typ,
    input  logic                 wrb_mispred_tgt,
    input  logic [BR_TYPE_W-1:0] wrb_branch_type,
    input  logic [XLEN-1:0]      wrb_target,
    output logic                 bc_wr_en,
    output logic [XLEN-1:0]      bc_wr_pc,
    output logic [BR_TYPE_W-1:0] bc_wr_type,
    output logic [XLEN-1:0]      bc_wr_target,
    output logic                 bc_inv_en,
    output logic [BC_SIZE-1:0]   bc_inv_idx,
    output logic                 bpu_busy,
    output logic [15:0]          uq_drop_cnt
);

    sched_state_e       state;
    logic [BC_SIZE-1:0] walk_idx;
    logic [15:0]        drop_cnt;

    bc_upd_t upd_in;
    bc_upd_t upd_head;
    logic    qualify;
    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_push;
    logic    fifo_pop;
    logic    wr_from_fifo;
    logic    bypass_take;
    logic    upd_offered;
    logic    room;
    logic    drop_evt;

    // Only mispredicted resolutions change what the cache should hold.
    assign qualify = wrb_update_bpu & (wrb_mispred_typ | wrb_mispred_tgt);

    assign upd_in.pc      = wrb_pc;
    assign upd_in.br_type = br_type_e'(wrb_branch_type);
    assign upd_in.target  = wrb_target;

    // The head drains one entry per cycle whenever no walk is in progress.
    assign wr_from_fifo = (state == ST_IDLE) && !fifo_empty;
    assign fifo_pop     = wr_from_fifo;

`ifdef BC_UPD_BYPASS_EN
    assign bypass_take = (state == ST_IDLE) && fifo_empty && !bpu_flush && qualify;
`else
    assign bypass_take = 1'b0;
`endif

    // A flush discards the same-cycle update; a bypassed update never enters the queue.
    assign upd_offered = qualify && !bpu_flush && !bypass_take;
    assign room        = !fifo_full || fifo_pop;
    assign fifo_push   = upd_offered && room;
    assign drop_evt    = upd_offered && !room;

    bc_upd_fifo #(
        .WIDTH      (BC_UPD_W),
        .DEPTH_LOG2 (UQ_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (bpu_flush),
        .push      (fifo_push),
        .push_data (upd_in),
        .pop       (fifo_pop),
        .pop_data  (upd_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Scheduler FSM: reset and flush both restart the invalidation walk from entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_FLUSH;
            walk_idx <= '0;
        end else if (bpu_flush) begin
            state    <= ST_FLUSH;
            walk_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    walk_idx <= walk_idx + 1'b1;
                    if (&walk_idx) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_FLUSH;
                    walk_idx <= '0;
                end
            endcase
        end
    end

    // Saturating count of updates lost to a full queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Output drive: writes only outside a walk, so write and invalidate never coincide.
    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        bc_wr_en     = 1'b0;
        bc_wr_pc     = '0;
        bc_wr_type   = '0;
        bc_wr_target = '0;
        bc_inv_en    = 1'b0;
        bc_inv_idx   = '0;
        bpu_busy     = 1'b0;
        uq_drop_cnt  = '0;
        if (!reset) begin
            if (wr_from_fifo) begin
                bc_wr_en     = 1'b1;
                bc_wr_pc     = upd_head.pc;
                bc_wr_type   = upd_head.br_type;
                bc_wr_target = upd_head.target;
            end else if (bypass_take) begin
                bc_wr_en     = 1'b1;
                bc_wr_pc     = upd_in.pc;
                bc_wr_type   = upd_in.br_type;
                bc_wr_target = upd_in.target;
            end
            if (state == ST_FLUSH) begin
                bc_inv_en  = 1'b1;
                bc_inv_idx = walk_idx;
                bpu_busy   = 1'b1;
            end
            uq_drop_cnt = drop_cnt;
        end
    end

endmodule

// File: doc/bc_update_sched.md
BC_UPDATE_SCHED -- requirements
Module: bc_update_sched

Interface
REQ-001 SHALL have parameter BC_SIZE, default 8: log2 of branch cache entries.
REQ-002 SHALL have parameter UQ_DEPTH_LOG2, default 2: log2 of update-queue depth.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- bpu_flush  in  1  request invalidation of all branch cache entries.
- wrb_update_bpu  in  1  branch resolution report valid.
- wrb_pc  in  32  PC of resolved instruction.
- wrb_mispred_typ  in  1  branch type mispredicted.
- wrb_mispred_tgt  in  1  target mispredicted.
- wrb_branch_type  in  3  actual branch type.
- wrb_target  in  32  actual target.
- bc_wr_en  out  1  write one branch cache entry this cycle.
- bc_wr_pc  out  32  PC for write (index and tag source).
- bc_wr_type  out  3  type for write.
- bc_wr_target  out  32  target for write.
- bc_inv_en  out  1  invalidate one entry this cycle.
- bc_inv_idx  out  BC_SIZE  entry to invalidate.
- bpu_busy  out  1  flush walk in progress.
- uq_drop_cnt  out  16  saturating count of dropped updates.

Function
REQ-004 SHALL enqueue {wrb_pc, wrb_branch_type, wrb_target} when wrb_update_bpu & (wrb_mispred_typ | wrb_mispred_tgt); other reports SHALL be ignored.
REQ-005 SHALL hold updates in a FIFO of 2^UQ_DEPTH_LOG2 entries, in order.
REQ-006 SHALL drive bc_wr_en = 1 with head fields whenever state is IDLE and the FIFO is non-empty; it SHALL pop the head at that edge, one entry per cycle.
REQ-007 SHALL take one cycle from enqueue to write: an update at cycle N appears on bc_wr_* at N+1 if the FIFO was empty.
REQ-008 SHALL accept an enqueue when full only if a pop happens in the same cycle; otherwise it SHALL drop the update and increment uq_drop_cnt, saturating at 0xFFFF.
REQ-009 SHALL implement FSM states IDLE and FLUSH, with index counter walk_idx of BC_SIZE bits.
REQ-010 SHALL, on bpu_flush in any state, move to FLUSH with walk_idx = 0, clear the FIFO, and discard any same-cycle update.
REQ-011 SHALL, in FLUSH, drive bc_inv_en = 1, bc_inv_idx = walk_idx and bpu_busy = 1, and increment walk_idx each cycle.
REQ-012 SHALL return to IDLE after the cycle in which walk_idx = 2^BC_SIZE-1, with no wrap-around revisit.
REQ-013 SHALL enqueue updates arriving during FLUSH normally, and drain them only after returning to IDLE.
REQ-014 SHALL hold bc_wr_en = 0 in FLUSH, and SHALL never assert bc_wr_en and bc_inv_en in the same cycle.

Reset
REQ-015 SHALL, while reset = 1, drive all outputs to 0, empty the FIFO and zero uq_drop_cnt.
REQ-016 SHALL leave reset in state FLUSH with walk_idx = 0, so the first cycle after deassertion has bc_inv_en = 1 and bc_inv_idx = 0.
REQ-017 SHALL, on reset mid-walk or mid-drain, abandon the operation and restart the walk from 0.

Configuration
REQ-018 SHALL, with BC_UPD_BYPASS_EN defined, drive a qualifying update combinationally onto bc_wr_* in the same cycle when IDLE, FIFO empty and bpu_flush = 0, without enqueueing it (latency 0).
REQ-019 SHALL, without BC_UPD_BYPASS_EN, always route updates through the FIFO (latency 1).

Structure
REQ-020 SHALL take XLEN and branch-type encodings from the shared package; the FSM state encoding SHALL be a typedef there.
REQ-021 SHALL implement the queue as sub-module bc_upd_fifo (parameterised width and depth; push, pop, full, empty, clear).

Verification
REQ-022 Bench SHALL cover (BC_SIZE=3, UQ_DEPTH_LOG2=2, no bypass):
- Reset released -> bc_inv_en high 8 cycles, idx 0..7, bpu_busy low on cycle 9.
- One mispredict, pc=0x100, tgt=0x200, type=3 at N -> bc_wr_en at N+1 with those values.
- 6 back-to-back mispredicts, IDLE -> all 6 written in order, uq_drop_cnt = 0.
- 6 mispredicts during FLUSH -> first 4 written after walk, uq_drop_cnt = 2.
- bpu_flush with 3 queued and an update in the same cycle -> no bc_wr_en until walk ends, then none.
- With BC_UPD_BYPASS_EN, single update at N -> bc_wr_en at N.
